hub75_stream_writer: RTL and testbench
======================================

# hub75_stream_writer

Upstream stage of `hub75_driver`. It converts a framed pixel stream (valid/ready, start-of-frame, end-of-line) into the driver's frame-buffer write port (`i_framebuf_wr_addr`, `i_framebuf_wr_data`, `i_framebuf_wr_en`). It tracks raster position, produces row-major addresses, and detects and recovers from malformed frames, so that a bad source cannot leave writes permanently misaligned.

## Interface
- `hpixel_p`, 64: display width in pixels.
- `vpixel_p`, 64: display height in pixels.
- `bpp_p`, 8: bits per colour channel.
- `addr_width_p` (localparam), `$clog2(hpixel_p*vpixel_p)`: 12 at defaults.

Ports:
- `clk`  in  1  single clock; every flop is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_enable`  in  1  block enable.
- `i_pix_valid`  in  1  source beat valid.
- `o_pix_ready`  out  1  sink ready.
- `i_pix_data`  in  3*bpp_p  pixel packed as {R,G,B}.
- `i_pix_sof`  in  1  beat is the first pixel of a frame.
- `i_pix_eol`  in  1  beat is the last pixel of a line.
- `o_wr_addr`  out  addr_width_p  frame-buffer address, y*hpixel_p + x.
- `o_wr_data`  out  3*bpp_p  registered copy of the pixel.
- `o_wr_en`  out  1  write strobe.
- `o_frame_done`  out  1  one-cycle pulse when a complete frame has been written.
- `o_err_sof`  out  1  one-cycle pulse on an unexpected SOF.
- `o_err_eol`  out  1  one-cycle pulse on line-length mismatch.
- `o_frame_cnt`  out  16  count of completed frames; wraps modulo 2^16.

## Operation
- Accept = `i_pix_valid & o_pix_ready`. `o_pix_ready` = `i_enable` (combinational); the frame-buffer write never stalls.
- Counters: `x` in [0, hpixel_p-1], `y` in [0, vpixel_p-1].
- FSM states: `WAIT_SOF`, `ACTIVE`.
- `WAIT_SOF`:
  - An accepted beat with `sof=0` is dropped: no write, no error.
  - An accepted beat with `sof=1` writes address 0, sets x=1, y=0 and moves to `ACTIVE`.
  - Special case `hpixel_p=1`: this beat is line end; apply the line-end rules below.
- `ACTIVE`, accepted beat with `sof=0`: write at (x,y).
- Line end occurs at `eol=1` or at x==hpixel_p-1, whichever comes first. On line end: x←0, y←y+1.
- `o_err_eol` pulses if `eol` and x==hpixel_p-1 disagree, i.e. a short line (early EOL) or a long line (no EOL at the last column). On a short line the remaining pixels of that row are left unwritten.
- Line end at y==vpixel_p-1:
  - `o_frame_done` pulses and `o_frame_cnt` increments.
  - Next state is `WAIT_SOF`.
  - Beats after this point and before the next SOF are dropped.
- `ACTIVE`, accepted beat with `sof=1`:
  - `o_err_sof` pulses.
  - The frame restarts: the beat is written at address 0, x=1, y=0.
  - `o_frame_done` does not pulse.
- Simultaneous `sof` and `eol` on one beat: SOF handling takes precedence. The EOL is evaluated against x=0, so an `err_eol` pulse is possible.
- `i_enable` low:
  - No accepts.
  - The FSM is forced to `WAIT_SOF` and x, y are cleared on the next edge.
  - `o_frame_cnt` is held.
- Address arithmetic: `y*hpixel_p + x` is computed in addr_width_p bits. Use a running base register, `base += hpixel_p` per line, with no multiplier.

## Timing
- Latency: a beat accepted on edge n drives `o_wr_en`, `o_wr_addr` and `o_wr_data` during cycle n+1.
- `o_wr_en` is high for exactly one cycle per written beat.
- `o_frame_done`, `o_err_*` and the `o_frame_cnt` update are registered and coincide with the `o_wr_en` of the beat that caused them.
- Back-to-back beats give one write per cycle, so full throughput.
- Reset values:
  - All outputs 0 except `o_pix_ready`, which follows `i_enable`.
  - State `WAIT_SOF`; x=y=base=0.
- Reset asserted mid-frame: the next cycle has no write and the state is `WAIT_SOF`. A write already registered is discarded, because `o_wr_en` is cleared.
- Disable mid-frame takes effect on the next edge. A write registered on that edge from the final accepted beat still appears.

## Structure
- Package `hub75_pkg` holds:
  - `rgb_t`, packed {R,G,B} of bpp_p bits each.
  - The state enum `wr_state_e`.
  - The frame-size and address-width constant functions, shared with the driver.
- One sub-module, `hub75_raster_counter`, is natural. It holds the x, y and base counters and provides `line_end`, `frame_end` and `addr`, with synchronous clear and advance inputs.
- The FSM, error logic and output registers stay in the top level.

## Test plan
- Clean frame: 4096 beats, SOF on beat 0, EOL every 64th. Expect writes to addresses 0..4095 in order, one `o_frame_done` pulse on the write to 4095, `o_frame_cnt`=1, no errors.
- Pre-SOF garbage: 10 beats without SOF, then a clean frame. Expect the 10 beats dropped with no writes and the first write at address 0.
- Short line: EOL on x=40 of row 3. Expect `o_err_eol` pulse; the next beat is written at address 4*64=256.
- Long line: no EOL at x=63 of row 5. Expect `o_err_eol` pulse; the next beat is written at address 384.
- Mid-frame SOF at row 10, x=7. Expect `o_err_sof` pulse, that beat written at address 0, no `o_frame_done`; a subsequent complete frame gives `o_frame_cnt`=1.
- Reset or disable mid-frame, then re-enable with a clean frame. Expect the first write at address 0, with all outputs 0 during reset.

Source files
------------

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and sizing helpers for the hub75 pixel path
// Purpose: colour pixel type, writer state encoding, frame-size/address-width
//          constant functions used by the stream writer and the driver.
// Ports:   none (package).
package hub75_pkg;

    localparam int bpp_c = 8;

    typedef struct packed {
        logic [bpp_c-1:0] r;
        logic [bpp_c-1:0] g;
        logic [bpp_c-1:0] b;
    } rgb_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } wr_state_e;

    function automatic int frame_size(input int h, input int v);
        return h * v;
    endfunction

    // Never returns 0 so degenerate 1x1 displays still get a 1-bit counter.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int addr_width(input int h, input int v);
        return clog2_min1(frame_size(h, v));
    endfunction

endpackage

// File: rtl/hub75_stream_writer_if.sv
// rtl/hub75_stream_writer_if.sv - framed pixel stream handshake bundle
// Purpose: groups the valid/ready pixel beat with its sof/eol framing flags.
// Ports:   i_pix_valid, i_pix_data {R,G,B}, i_pix_sof, i_pix_eol from the
//          source (master); o_pix_ready from the sink (slave).
interface hub75_stream_writer_if #(
    parameter int bpp_p = 8
);
    logic               i_pix_valid;
    logic               o_pix_ready;
    logic [3*bpp_p-1:0] i_pix_data;
    logic               i_pix_sof;
    logic               i_pix_eol;

    modport master (
        output i_pix_valid,
        output i_pix_data,
        output i_pix_sof,
        output i_pix_eol,
        input  o_pix_ready
    );

    modport slave (
        input  i_pix_valid,
        input  i_pix_data,
        input  i_pix_sof,
        input  i_pix_eol,
        output o_pix_ready
    );
endinterface

// File: rtl/hub75_raster_counter.sv
// rtl/hub75_raster_counter.sv - x/y/base raster position tracker
// Purpose: keeps the current column, row and row base address; reports the
//          address of the beat being written and whether it ends a line/frame.
// Ports:   clk, rst_n (sync active-low); clr_i clears position; adv_i consumes
//          one beat; start_i treats the beat as pixel (0,0); eol_i forces line
//          end; addr_o, last_col_o, line_end_o, frame_end_o describe the beat.
module hub75_raster_counter
    import hub75_pkg::*;
#(
    parameter  int hpixel_p     = 64,
    parameter  int vpixel_p     = 64,
    localparam int addr_width_p = addr_width(hpixel_p, vpixel_p)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    adv_i,
    input  logic                    start_i,
    input  logic                    eol_i,
    output logic [addr_width_p-1:0] addr_o,
    output logic                    last_col_o,
    output logic                    line_end_o,
    output logic                    frame_end_o
);
    localparam int xw_c = clog2_min1(hpixel_p);
    localparam int yw_c = clog2_min1(vpixel_p);

    logic [xw_c-1:0]         x_q, x_d, x_cur;
    logic [yw_c-1:0]         y_q, y_d, y_cur;
    logic [addr_width_p-1:0] base_q, base_d, base_cur;

    always_comb begin
        // A start beat is evaluated as if the raster were already at (0,0),
        // so restart and normal advance share one datapath.
        x_cur    = start_i ? '0 : x_q;
        y_cur    = start_i ? '0 : y_q;
        base_cur = start_i ? '0 : base_q;

        last_col_o  = (x_cur == xw_c'(hpixel_p - 1));
        line_end_o  = last_col_o | eol_i;
        frame_end_o = line_end_o & (y_cur == yw_c'(vpixel_p - 1));
        addr_o      = base_cur + addr_width_p'(x_cur);

        x_d    = x_q;
        y_d    = y_q;
        base_d = base_q;
        if (clr_i) begin
            x_d    = '0;
            y_d    = '0;
            base_d = '0;
        end else if (adv_i) begin
            if (line_end_o) begin
                x_d = '0;
                if (frame_end_o) begin
                    y_d    = '0;
                    base_d = '0;
                end else begin
                    y_d    = y_cur + yw_c'(1);
                    base_d = base_cur + addr_width_p'(hpixel_p);
                end
            end else begin
                x_d    = x_cur + xw_c'(1);
                y_d    = y_cur;
                base_d = base_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            base_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/hub75_stream_writer.sv
// rtl/hub75_stream_writer.sv - framed pixel stream to frame-buffer write port
// Purpose: accepts sof/eol-framed pixels, generates row-major write addresses,
//          flags malformed frames and resynchronises on the next SOF.
// Ports:   clk, rst_n (sync active-low), i_enable; pix (stream slave);
//          o_wr_addr/o_wr_data/o_wr_en write port; o_frame_done, o_err_sof,
//          o_err_eol pulses; o_frame_cnt completed-frame counter.
module hub75_stream_writer
    import hub75_pkg::*;
#(
    parameter  int hpixel_p     = 64,
    parameter  int vpixel_p     = 64,
    parameter  int bpp_p        = 8,
    localparam int addr_width_p = addr_width(hpixel_p, vpixel_p)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    hub75_stream_writer_if.slave    pix,
    output logic [addr_width_p-1:0] o_wr_addr,
    output logic [3*bpp_p-1:0]      o_wr_data,
    output logic                    o_wr_en,
    output logic                    o_frame_done,
    output logic                    o_err_sof,
    output logic                    o_err_eol,
    output logic [15:0]             o_frame_cnt
);
    wr_state_e               state_q;
    logic [addr_width_p-1:0] wr_addr_q;
    logic [3*bpp_p-1:0]      wr_data_q;
    logic                    wr_en_q;
    logic                    frame_done_q;
    logic                    err_sof_q;
    logic                    err_eol_q;
    logic [15:0]             frame_cnt_q;

    logic                    accept;
    logic                    start;
    logic                    write;
    logic [addr_width_p-1:0] beat_addr;
    logic                    last_col;
    logic                    line_end;
    logic                    frame_end;

    // The write port never stalls, so readiness is purely the enable.
    assign pix.o_pix_ready = i_enable;

    assign accept = pix.i_pix_valid & i_enable;
    assign start  = accept & pix.i_pix_sof;
    // Outside a frame only an SOF beat is written; everything else is dropped.
    assign write  = start | (accept & (state_q == ACTIVE));

    hub75_raster_counter #(
        .hpixel_p (hpixel_p),
        .vpixel_p (vpixel_p)
    ) u_raster (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (~i_enable),
        .adv_i       (write),
        .start_i     (pix.i_pix_sof),
        .eol_i       (pix.i_pix_eol),
        .addr_o      (beat_addr),
        .last_col_o  (last_col),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WAIT_SOF;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
            err_eol_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            wr_en_q      <= write;
            frame_done_q <= write & frame_end;
            err_sof_q    <= start & (state_q == ACTIVE);
            // Early EOL and missing EOL both show up as eol disagreeing with
            // the last-column position.
            err_eol_q    <= write & (pix.i_pix_eol != last_col);
            if (write) begin
                wr_addr_q <= beat_addr;
                wr_data_q <= pix.i_pix_data;
            end
            if (write && frame_end) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end

            if (!i_enable) begin
                state_q <= WAIT_SOF;
            end else if (write) begin
                state_q <= (frame_end && line_end) ? WAIT_SOF : ACTIVE;
            end
        end
    end

    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_wr_en      = wr_en_q;
    assign o_frame_done = frame_done_q;
    assign o_err_sof    = err_sof_q;
    assign o_err_eol    = err_eol_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_hub75_stream_writer.sv
// tb/tb_hub75_stream_writer.sv - scoreboard bench for hub75_stream_writer
module tb_hub75_stream_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    logic [11:0] o_wr_addr;
    logic [23:0] o_wr_data;
    logic        o_wr_en, o_frame_done, o_err_sof, o_err_eol;
    logic [15:0] o_frame_cnt;

    hub75_stream_writer_if #(.bpp_p(8)) pix ();

    hub75_stream_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (en),
        .pix          (pix.slave),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_wr_en      (o_wr_en),
        .o_frame_done (o_frame_done),
        .o_err_sof    (o_err_sof),
        .o_err_eol    (o_err_eol),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // {addr, data, done, err_sof, err_eol, frame_cnt}
    logic [54:0] sb[$];

    int   m_x = 0, m_y = 0, m_cnt = 0;
    bit   m_active = 0;
    logic rst_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) rst_prev = rst_n;

    always @(negedge clk) begin
        if (!rst_prev) begin
            check_eq("rst_outs", {o_wr_addr, o_wr_data, o_wr_en, o_frame_done,
                                  o_err_sof, o_err_eol, o_frame_cnt}, 64'd0);
        end else if (o_wr_en === 1'b1) begin
            if (sb.size() == 0) check_eq("unexp_wr", {52'd0, o_wr_addr}, 64'hFFFF);
            else check_eq("wr", {o_wr_addr, o_wr_data, o_frame_done, o_err_sof,
                                 o_err_eol, o_frame_cnt}, sb.pop_front());
        end else begin
            check_eq("idle_flags", {o_wr_en, o_frame_done, o_err_sof, o_err_eol}, 64'd0);
        end
        check_eq("ready", pix.o_pix_ready, en);
    end

    // Drive one accepted beat and predict its effect with a plain raster model.
    task automatic send(input bit sof, input bit eol);
        logic [23:0] d;
        bit wr, done, esof, eeol, last;
        int addr;
        d = 24'($urandom);
        @(posedge clk); #1;
        pix.i_pix_valid = 1'b1;
        pix.i_pix_sof   = sof;
        pix.i_pix_eol   = eol;
        pix.i_pix_data  = d;
        done = 0; esof = 0; eeol = 0;
        if (sof) begin
            esof = m_active;
            m_x = 0; m_y = 0; m_active = 1; wr = 1;
        end else begin
            wr = m_active;
        end
        if (wr) begin
            addr = m_y * 64 + m_x;
            last = (m_x == 63);
            eeol = (eol != last);
            if (eol || last) begin
                m_x = 0;
                if (m_y == 63) begin
                    m_y = 0; m_active = 0; done = 1; m_cnt++;
                end else begin
                    m_y++;
                end
            end else begin
                m_x++;
            end
            sb.push_back({12'(addr), d, done, esof, eeol, 16'(m_cnt)});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pix.i_pix_valid = 1'b0;
            pix.i_pix_sof   = 1'b0;
            pix.i_pix_eol   = 1'b0;
        end
    endtask

    // Full frame with optional short-line row/col, long-line row, and an
    // early stop position (-1 disables each).
    task automatic frame(input int sr, input int sx, input int lr, input int stop_r, input int stop_x);
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x++) begin
                if (y == stop_r && x == stop_x) return;
                if (y == sr && x == sx) begin
                    send(0, 1);
                    break;
                end
                send(x == 0 && y == 0, x == 63 && y != lr);
            end
        end
    endtask

    task automatic drain_and_check_cnt(input string tag);
        idle(3);
        @(negedge clk);
        check_eq(tag, {48'd0, o_frame_cnt}, 64'(m_cnt));
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic disable_for(input int n);
        @(posedge clk); #1;
        en = 1'b0;
        pix.i_pix_valid = 1'b1;
        pix.i_pix_sof   = 1'b1;
        m_active = 0; m_x = 0; m_y = 0;
        repeat (n) @(posedge clk);
        #1;
        pix.i_pix_valid = 1'b0;
        pix.i_pix_sof   = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        pix.i_pix_valid = 1'b0;
        pix.i_pix_sof   = 1'b0;
        pix.i_pix_eol   = 1'b0;
        pix.i_pix_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        idle(2);

        // Pre-SOF garbage then a clean frame.
        for (int i = 0; i < 10; i++) send(0, i[0]);
        frame(-1, -1, -1, -1, -1);
        drain_and_check_cnt("cnt_clean");
        check_eq("cnt_clean_is_1", {48'd0, o_frame_cnt}, 64'd1);

        // Short line on row 3 (EOL at x=40), long line on row 5.
        frame(3, 40, 5, -1, -1);
        drain_and_check_cnt("cnt_errlines");

        // SOF and EOL on one beat, a few more beats, then disable mid-frame.
        send(1, 1);
        for (int i = 0; i < 5; i++) send(0, 0);
        disable_for(3);
        frame(-1, -1, -1, -1, -1);
        drain_and_check_cnt("cnt_after_disable");

        // Mid-frame SOF at row 10, x=7, then a complete restarted frame.
        frame(-1, -1, -1, 10, 7);
        frame(-1, -1, -1, -1, -1);
        drain_and_check_cnt("cnt_after_midsof");

        // Partial frame, reset asserted together with a valid beat.
        frame(-1, -1, -1, 20, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        pix.i_pix_valid = 1'b1;
        pix.i_pix_sof   = 1'b0;
        m_active = 0; m_x = 0; m_y = 0; m_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pix.i_pix_valid = 1'b0;
        frame(-1, -1, -1, -1, -1);
        drain_and_check_cnt("cnt_after_reset");
        check_eq("cnt_after_reset_is_1", {48'd0, o_frame_cnt}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
